// File: rtl/fd_stage_buffer.sv
// fd_stage_buffer: fetch-to-decode pipeline register with a valid/ready handshake,
// a flush that inserts a bubble, and misaligned-PC exception tagging.
// Optional macro FD_SKID_BUFFER_EN: builds a two-entry skid FIFO with a registered
// in_ready. Without the macro, a single entry is built and in_ready is combinational.
// Every decode-side output comes straight from a register. A slot that goes
// empty is cleared, so out_instr reads 0 while out_valid is low.

module fd_stage_buffer #(
    parameter int IW = 32,
    parameter int AW = 32,
    parameter int SW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [AW-1:0] in_pc,
    input  logic [SW-1:0] in_side,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic [AW-1:0] out_pc8,
    output logic [SW-1:0] out_side,
    output logic          out_exc
);

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
        logic [AW-1:0] pc8;
        logic [SW-1:0] side;
        logic          exc;
    } entry_t;

    entry_t new_entry;
    logic   new_exc;
    logic   accept;
    logic   consume;

    // Build the entry captured on accept; pc8 is computed here so the output is a pure register.
    always_comb begin
        new_exc         = |in_pc[1:0];
        new_entry.exc   = new_exc;
        new_entry.instr = new_exc ? '0 : in_instr;
        new_entry.pc    = in_pc;
        new_entry.pc8   = in_pc + AW'(8);
        new_entry.side  = in_side;
    end

`ifdef FD_SKID_BUFFER_EN

    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    logic [1:0] cnt_q, cnt_d;
    logic       in_ready_q, in_ready_d;

    assign in_ready  = in_ready_q;
    assign out_valid = (cnt_q != 2'd0);
    assign accept    = in_valid && in_ready_q;
    assign consume   = out_valid && out_ready;

    // Occupancy and slot movement; slot0 feeds decode, slot1 catches the entry that arrives while decode stalls.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        if (flush) begin
            slot0_d = '0;
            slot1_d = '0;
            cnt_d   = 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (accept) begin
                        slot0_d = new_entry;
                        cnt_d   = 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && consume) begin
                        slot0_d = new_entry;
                    end else if (accept) begin
                        slot1_d = new_entry;
                        cnt_d   = 2'd2;
                    end else if (consume) begin
                        slot0_d = '0;
                        cnt_d   = 2'd0;
                    end
                end
                2'd2: begin
                    if (consume) begin
                        slot0_d = slot1_q;
                        slot1_d = '0;
                        cnt_d   = 2'd1;
                    end
                end
                default: begin
                    slot0_d = '0;
                    slot1_d = '0;
                    cnt_d   = 2'd0;
                end
            endcase
        end
        in_ready_d = (cnt_d != 2'd2);
    end

    // State registers; in_ready comes back high straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_q    <= '0;
            slot1_q    <= '0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

`else

    entry_t slot0_q, slot0_d;
    logic   valid_q, valid_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign accept    = in_valid && in_ready;
    assign consume   = valid_q && out_ready;

    // Single entry: flush wins, an accept replaces (even alongside a consume), a bare consume empties.
    always_comb begin
        slot0_d = slot0_q;
        valid_d = valid_q;
        if (flush) begin
            slot0_d = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            slot0_d = new_entry;
            valid_d = 1'b1;
        end else if (consume) begin
            slot0_d = '0;
            valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_q <= '0;
            valid_q <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            valid_q <= valid_d;
        end
    end

`endif

    assign out_instr = slot0_q.instr;
    assign out_pc    = slot0_q.pc;
    assign out_pc8   = slot0_q.pc8;
    assign out_side  = slot0_q.side;
    assign out_exc   = slot0_q.exc;

endmodule

// File: tb/tb_fd_stage_buffer.sv
// tb_fd_stage_buffer: directed and back-pressure bench for fd_stage_buffer.
// Honours FD_SKID_BUFFER_EN in the same way as the design.

module tb_fd_stage_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [0:0]  in_side;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc8;
    logic [0:0]  out_side;
    logic        out_exc;

    int n_checks = 0;
    int n_errors = 0;

    fd_stage_buffer #(.IW(32), .AW(32), .SW(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_side   (in_side),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_pc8   (out_pc8),
        .out_side  (out_side),
        .out_exc   (out_exc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc, input logic ordy);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        in_side   = pc[2];
        out_ready = ordy;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        repeat (3) step();
    endtask

    logic [31:0] q_pc[$];
    logic [31:0] pc_v;
    logic        exp_rdy;
    int          acc;
    int          cyc;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);

        // reset and basic flow
        step();
        chk("rst_valid", out_valid, 0);
        step();
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_pc8", out_pc8, 0);
        chk("rst_side", out_side, 0);
        chk("rst_exc", out_exc, 0);
        reset = 1'b0;
        drive(1'b1, 32'h8C010004, 32'h00003000, 1'b1);
        #1;
        chk("post_rst_ready", in_ready, 1);
        step();
        chk("basic_valid", out_valid, 1);
        chk("basic_pc", out_pc, 32'h3000);
        chk("basic_pc8", out_pc8, 32'h3008);
        chk("basic_instr", out_instr, 32'h8C010004);
        chk("basic_exc", out_exc, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_instr", out_instr, 0);

        // stall hold
        drive(1'b1, 32'hAAAA3004, 32'h00003004, 1'b0);
        step();
        drive(1'b1, 32'hAAAA3008, 32'h00003008, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", out_valid, 1);
            chk("stall_pc", out_pc, 32'h3004);
            chk("stall_instr", out_instr, 32'hAAAA3004);
            chk("stall_pc8", out_pc8, 32'h300C);
            chk("stall_side", out_side, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("unstall_valid", out_valid, 1);
        chk("unstall_pc", out_pc, 32'h3008);
        chk("unstall_instr", out_instr, 32'hAAAA3008);
        step();
        chk("no_dup_valid", out_valid, 0);
        chk("no_dup_instr", out_instr, 0);
        drain();

        // flush alongside a consume and an offered entry
        drive(1'b1, 32'hBBBB300C, 32'h0000300C, 1'b0);
        step();
        drive(1'b1, 32'hCCCC3010, 32'h00003010, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_pre_pc", out_pc, 32'h300C);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("flush_valid", out_valid, 0);
        chk("flush_instr", out_instr, 0);
        step();
        chk("flush_gone_valid", out_valid, 0);
        chk("flush_gone_pc", out_pc, 0);

        // misaligned PC then wrap-around
        drive(1'b1, 32'h12345678, 32'h00003002, 1'b1);
        step();
        chk("mis_exc", out_exc, 1);
        chk("mis_instr", out_instr, 0);
        chk("mis_pc", out_pc, 32'h3002);
        chk("mis_pc8", out_pc8, 32'h300A);
        chk("mis_valid", out_valid, 1);
        drive(1'b1, 32'h0BADF00D, 32'hFFFFFFFC, 1'b1);
        step();
        chk("wrap_pc8", out_pc8, 32'h00000004);
        chk("wrap_exc", out_exc, 0);
        chk("wrap_instr", out_instr, 32'h0BADF00D);
        drain();
        chk("idle_exc", out_exc, 0);

        // reset asserted during a stall
        drive(1'b1, 32'hDDDD3020, 32'h00003020, 1'b0);
        step();
        drive(1'b1, 32'hDDDD3024, 32'h00003024, 1'b0);
        step();
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        chk("rst_stall_valid", out_valid, 0);
        chk("rst_stall_pc", out_pc, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        chk("rst_stall_ready", in_ready, 1);
        step();
        chk("rst_stall_gone", out_valid, 0);

        // random back-pressure with a PC scoreboard
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            pc_v = 32'h00010000 + 32'(acc * 4);
            drive(1'($urandom_range(0, 1)), pc_v ^ 32'hA5A50000, pc_v, 1'($urandom_range(0, 1)));
            #1;
`ifdef FD_SKID_BUFFER_EN
            exp_rdy = (q_pc.size() != 2);
`else
            exp_rdy = (q_pc.size() == 0) || out_ready;
`endif
            chk("rand_valid", out_valid, q_pc.size() != 0);
            chk("rand_ready", in_ready, exp_rdy);
            chk("rand_depth_ok", q_pc.size() <= 2, 1);
            if (out_valid && out_ready && q_pc.size() != 0) begin
                chk("rand_pc", out_pc, q_pc[0]);
                chk("rand_instr", out_instr, q_pc[0] ^ 32'hA5A50000);
                chk("rand_side", out_side, q_pc[0][2]);
                void'(q_pc.pop_front());
            end
            if (in_valid && in_ready) begin
                q_pc.push_back(pc_v);
                acc++;
            end
            step();
            cyc++;
        end
        chk("rand_accepted", acc, 1000);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 10 && q_pc.size() != 0; i++) begin
            #1;
            if (out_valid && q_pc.size() != 0) begin
                chk("tail_pc", out_pc, q_pc[0]);
                void'(q_pc.pop_front());
            end
            step();
        end
        chk("tail_empty", q_pc.size(), 0);
        chk("tail_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
